// File: rtl/sap_ctrl_seq.sv
// SAP-class CPU control sequencer: one-hot T-state ring, opcode decode,
// flag-driven conditional jumps, optional early return to fetch, halt.
module sap_ctrl_seq #(
  parameter int OP_W      = 4,
  parameter int T_MAX     = 6,
  parameter int EARLY_END = 1
) (
  input  logic             clock,
  input  logic             clr,
  input  logic [OP_W-1:0]  ri,
  input  logic             flag_z,
  input  logic             flag_c,
  output logic             Cp,
  output logic             Ep,
  output logic             Lm_barra,
  output logic             CE_barra,
  output logic             Li_barra,
  output logic             Ei_barra,
  output logic             La_barra,
  output logic             Ea,
  output logic             Su,
  output logic             Eu,
  output logic             Lb_barra,
  output logic             Lo_barra,
  output logic             Lp,
  output logic [T_MAX-1:0] t_state,
  output logic             instr_done,
  output logic             halted
);

  localparam logic [T_MAX-1:0] T1 = T_MAX'(1);

  // Opcodes compared against zero-extended 4-bit codes.
  logic op_lda, op_add, op_sub, op_jmp, op_jz, op_jc, op_out, op_hlt;
  assign op_lda = (ri == OP_W'(4'h0));
  assign op_add = (ri == OP_W'(4'h1));
  assign op_sub = (ri == OP_W'(4'h2));
  assign op_jmp = (ri == OP_W'(4'h3));
  assign op_jz  = (ri == OP_W'(4'h4));
  assign op_jc  = (ri == OP_W'(4'h5));
  assign op_out = (ri == OP_W'(4'hE));
  assign op_hlt = (ri == OP_W'(4'hF));

  // A corrupted (non one-hot) state decodes to nothing and recovers to T1.
  logic one_hot;
  logic active;
  logic last;
  logic take_jump;
  logic [T_MAX-1:0] t_next;
  logic             halted_next;

  assign one_hot = $onehot(t_state);
  assign active  = one_hot && !halted;

  // Output decode and last-active-state detection for the current T-state.
  always_comb begin
    Cp        = 1'b0;
    Ep        = 1'b0;
    Lm_barra  = 1'b1;
    CE_barra  = 1'b1;
    Li_barra  = 1'b1;
    Ei_barra  = 1'b1;
    La_barra  = 1'b1;
    Ea        = 1'b0;
    Su        = 1'b0;
    Eu        = 1'b0;
    Lb_barra  = 1'b1;
    Lo_barra  = 1'b1;
    Lp        = 1'b0;
    last      = 1'b0;
    take_jump = op_jmp || (op_jz && flag_z) || (op_jc && flag_c);
    if (active) begin
      if (t_state[0]) begin
        Ep       = 1'b1;
        Lm_barra = 1'b0;
      end
      if (t_state[1]) begin
        Cp = 1'b1;
      end
      if (t_state[2]) begin
        CE_barra = 1'b0;
        Li_barra = 1'b0;
        last     = !(op_lda || op_add || op_sub || op_jmp || op_jz ||
                     op_jc || op_out || op_hlt);
      end
      if (t_state[3]) begin
        if (op_lda || op_add || op_sub) begin
          Ei_barra = 1'b0;
          Lm_barra = 1'b0;
        end
        if (take_jump) begin
          Ei_barra = 1'b0;
          Lp       = 1'b1;
        end
        if (op_out) begin
          Ea       = 1'b1;
          Lo_barra = 1'b0;
        end
        last = op_jmp || op_jz || op_jc || op_out;
      end
      if (t_state[4]) begin
        if (op_lda) begin
          CE_barra = 1'b0;
          La_barra = 1'b0;
          last     = 1'b1;
        end
        if (op_add || op_sub) begin
          CE_barra = 1'b0;
          Lb_barra = 1'b0;
        end
      end
      if (t_state[5]) begin
        if (op_add || op_sub) begin
          Eu       = 1'b1;
          La_barra = 1'b0;
          Su       = op_sub;
          last     = 1'b1;
        end
      end
    end
    instr_done = active && ((EARLY_END != 0) ? last : t_state[T_MAX-1]);
  end

  // Next-state selection: recovery, halt hold, halt entry, early end, rotate.
  always_comb begin
    t_next      = {t_state[T_MAX-2:0], t_state[T_MAX-1]};
    halted_next = halted;
    if (!one_hot) begin
      t_next = T1;
    end else if (halted) begin
      t_next = t_state;
    end else if (t_state[3] && op_hlt) begin
      t_next      = t_state;
      halted_next = 1'b1;
    end else if ((EARLY_END != 0) && last) begin
      t_next = T1;
    end
  end

  // State register; clr aborts immediately to T1 and leaves halt.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      t_state <= T1;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      halted  <= halted_next;
    end
  end

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed bench for sap_ctrl_seq: default instance plus an
// EARLY_END=0 / T_MAX=8 instance sharing clock, reset and inputs.
module tb_sap_ctrl_seq;

  logic       clock = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] ri    = 4'h0;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;

  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp, done, hlt;
  logic [5:0] ts;
  logic cp8, ep8, lm8, ce8, li8, ei8, la8, ea8, su8, eu8, lb8, lo8, lp8, done8, hlt8;
  logic [7:0] ts8;

  int checks = 0;
  int errors = 0;

  // Control bundle order: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo Lp
  localparam logic [12:0] IDLE = 13'b0_0_1_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] M_CP = 13'h1000, M_EP = 13'h0800, M_LM = 13'h0400,
                          M_CE = 13'h0200, M_LI = 13'h0100, M_EI = 13'h0080,
                          M_LA = 13'h0040, M_EA = 13'h0020, M_SU = 13'h0010,
                          M_EU = 13'h0008, M_LB = 13'h0004, M_LO = 13'h0002,
                          M_LP = 13'h0001;

  logic [12:0] ctl, ctl8;
  assign ctl  = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp};
  assign ctl8 = {cp8, ep8, lm8, ce8, li8, ei8, la8, ea8, su8, eu8, lb8, lo8, lp8};

  sap_ctrl_seq dut (
    .clock(clock), .clr(clr), .ri(ri), .flag_z(flag_z), .flag_c(flag_c),
    .Cp(cp), .Ep(ep), .Lm_barra(lm), .CE_barra(ce), .Li_barra(li),
    .Ei_barra(ei), .La_barra(la), .Ea(ea), .Su(su), .Eu(eu),
    .Lb_barra(lb), .Lo_barra(lo), .Lp(lp), .t_state(ts),
    .instr_done(done), .halted(hlt)
  );

  sap_ctrl_seq #(.OP_W(4), .T_MAX(8), .EARLY_END(0)) dut8 (
    .clock(clock), .clr(clr), .ri(ri), .flag_z(flag_z), .flag_c(flag_c),
    .Cp(cp8), .Ep(ep8), .Lm_barra(lm8), .CE_barra(ce8), .Li_barra(li8),
    .Ei_barra(ei8), .La_barra(la8), .Ea(ea8), .Su(su8), .Eu(eu8),
    .Lb_barra(lb8), .Lo_barra(lo8), .Lp(lp8), .t_state(ts8),
    .instr_done(done8), .halted(hlt8)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    clr = 1'b0;
    @(negedge clock);
    clr = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_t", ts, 6'd1);
    chk("rst_halted", hlt, 1'b0);
    chk("rst_ctl", ctl, IDLE ^ (M_EP | M_LM));
    chk("rst_done", done, 1'b0);
    @(negedge clock);
    clr = 1'b1;
    #1;

    // LDA with early end: 1,2,4,8,16,1
    chk("lda_t1_ctl", ctl, IDLE ^ (M_EP | M_LM));
    tick(1); chk("lda_t2", ts, 6'd2);  chk("lda_t2_ctl", ctl, IDLE ^ M_CP);
    tick(1); chk("lda_t3", ts, 6'd4);  chk("lda_t3_ctl", ctl, IDLE ^ (M_CE | M_LI));
    chk("lda_t3_done", done, 1'b0);
    tick(1); chk("lda_t4", ts, 6'd8);  chk("lda_t4_ctl", ctl, IDLE ^ (M_EI | M_LM));
    tick(1); chk("lda_t5", ts, 6'd16); chk("lda_t5_ctl", ctl, IDLE ^ (M_CE | M_LA));
    chk("lda_t5_done", done, 1'b1);
    tick(1); chk("lda_wrap", ts, 6'd1);

    // SUB then ADD
    ri = 4'h2;
    tick(3); chk("sub_t4_ctl", ctl, IDLE ^ (M_EI | M_LM));
    tick(1); chk("sub_t5_ctl", ctl, IDLE ^ (M_CE | M_LB));
    chk("sub_t5_done", done, 1'b0);
    tick(1); chk("sub_t6", ts, 6'd32);
    chk("sub_t6_ctl", ctl, IDLE ^ (M_EU | M_LA | M_SU));
    chk("sub_t6_done", done, 1'b1);
    tick(1); chk("sub_wrap", ts, 6'd1);
    ri = 4'h1;
    tick(5); chk("add_t6_ctl", ctl, IDLE ^ (M_EU | M_LA));
    chk("add_t6_done", done, 1'b1);
    tick(1); chk("add_wrap", ts, 6'd1);

    // Conditional jumps
    ri = 4'h4; flag_z = 1'b1;
    tick(3); chk("jz1_t4_ctl", ctl, IDLE ^ (M_EI | M_LP)); chk("jz1_done", done, 1'b1);
    tick(1); chk("jz1_wrap", ts, 6'd1);
    flag_z = 1'b0;
    tick(3); chk("jz0_t4_ctl", ctl, IDLE); chk("jz0_done", done, 1'b1);
    tick(1); chk("jz0_wrap", ts, 6'd1);
    ri = 4'h5; flag_c = 1'b1;
    tick(3); chk("jc1_t4_ctl", ctl, IDLE ^ (M_EI | M_LP));
    tick(1); chk("jc1_wrap", ts, 6'd1);
    flag_c = 1'b0; flag_z = 1'b1;
    tick(3); chk("jc0_t4_ctl", ctl, IDLE);
    tick(1); chk("jc0_wrap", ts, 6'd1);
    flag_z = 1'b0;
    ri = 4'h3;
    tick(3); chk("jmp_t4_ctl", ctl, IDLE ^ (M_EI | M_LP));
    tick(1); chk("jmp_wrap", ts, 6'd1);
    ri = 4'hE;
    tick(3); chk("out_t4_ctl", ctl, IDLE ^ (M_EA | M_LO)); chk("out_done", done, 1'b1);
    tick(1); chk("out_wrap", ts, 6'd1);
    ri = 4'h7;
    tick(2); chk("nop_t3_ctl", ctl, IDLE ^ (M_CE | M_LI)); chk("nop_t3_done", done, 1'b1);
    tick(1); chk("nop_wrap", ts, 6'd1);

    // Halt
    ri = 4'hF;
    tick(3); chk("hlt_t4", ts, 6'd8); chk("hlt_t4_ctl", ctl, IDLE);
    chk("hlt_t4_halted", hlt, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("hlt_hold_t", ts, 6'd8);
      chk("hlt_hold_cp", cp, 1'b0);
      chk("hlt_hold_ctl", ctl, IDLE);
      chk("hlt_hold_halted", hlt, 1'b1);
      chk("hlt_hold_done", done, 1'b0);
    end
    @(negedge clock);
    clr = 1'b0;
    #1;
    chk("hlt_clr_t", ts, 6'd1);
    chk("hlt_clr_halted", hlt, 1'b0);
    chk("hlt_clr_ctl", ctl, IDLE ^ (M_EP | M_LM));
    @(negedge clock);
    clr = 1'b1;
    #1;

    // Async reset mid-T5 of ADD
    ri = 4'h1;
    tick(4); chk("abort_pre", ts, 6'd16); chk("abort_pre_lb", lb, 1'b0);
    #2;
    clr = 1'b0;
    #1;
    chk("abort_t", ts, 6'd1);
    chk("abort_lb", lb, 1'b1);
    chk("abort_ctl", ctl, IDLE ^ (M_EP | M_LM));
    @(negedge clock);
    clr = 1'b1;
    #1;

    // Illegal state recovery (LDA T5 corrupted to zero)
    ri = 4'h0;
    tick(4); chk("ill_pre", ts, 6'd16);
    @(negedge clock);
    force dut.t_state = 6'd0;
    #1;
    chk("ill_ctl", ctl, IDLE);
    chk("ill_done", done, 1'b0);
    release dut.t_state;
    tick(1); chk("ill_recover", ts, 6'd1);

    // EARLY_END=0, T_MAX=8, OUT
    ri = 4'hE;
    do_reset();
    chk("e0_t1", ts8, 8'd1);
    tick(3); chk("e0_t4", ts8, 8'd8); chk("e0_t4_ctl", ctl8, IDLE ^ (M_EA | M_LO));
    chk("e0_t4_done", done8, 1'b0);
    tick(1); chk("e0_t5_ctl", ctl8, IDLE);
    tick(2); chk("e0_t7", ts8, 8'd64); chk("e0_t7_ctl", ctl8, IDLE);
    tick(1); chk("e0_t8", ts8, 8'd128); chk("e0_t8_ctl", ctl8, IDLE);
    chk("e0_t8_done", done8, 1'b1);
    tick(1); chk("e0_wrap", ts8, 8'd1); chk("e0_wrap_done", done8, 1'b0);
    tick(3); chk("e0_2nd_t4_ctl", ctl8, IDLE ^ (M_EA | M_LO));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
